// File: rtl/soft_decode_scheduler_pkg.sv
// Shared types for the soft-decision decode scheduler: FSM states and result codes.
package soft_decode_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FB_RUN,
    LIK_RUN,
    RESULT
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  localparam int TAG_W_DEF = 8;

endpackage

// File: rtl/soft_decode_scheduler_if.sv
// Strand-in / result-out handshake bundle; the scheduler is the slave on both sides.
interface soft_decode_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_strand;
  logic [31:0]           in_N;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic [1:0]            out_err;

  modport master (
    output in_valid, in_strand, in_N, out_ready,
    input  in_ready, out_valid, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_strand, in_N, out_ready,
    output in_ready, out_valid, out_tag, out_err
  );
endinterface

// File: rtl/soft_decode_scheduler_phase_timer.sv
// Watchdog for one engine phase: counts while enabled, flags the last allowed cycle.
module phase_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // Expire is the (TIMEOUT-1)th count, so a phase gets exactly TIMEOUT cycles.
  assign expire = en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clear)         cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/soft_decode_scheduler.sv
// Sequencer for one soft-decision IDS decode: length check, alpha/beta in parallel,
// then likelihood recursion, then a tagged result held until the consumer takes it.
module soft_decode_scheduler
  import soft_decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int n          = 10,
  parameter int TIMEOUT    = 4096,
  parameter int TAG_W      = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  soft_decode_scheduler_if.slave bus,
  output logic [DATA_WIDTH-1:0] eng_strand,
  output logic [31:0]           eng_N,
  output logic                  start_fwd,
  output logic                  start_bwd,
  input  logic                  fwd_done,
  input  logic                  bwd_done,
  output logic                  start_lik,
  input  logic                  lik_done,
  output logic                  busy
);
  // n only sizes the engines; a non-positive codeword length is never meaningful.
  if (n < 1) begin : g_n_unsupported
  end

  state_t           state;
  logic [TAG_W-1:0] tag_cnt;
  logic             fwd_seen, bwd_seen;
  logic             both_done, len_bad, expire, tmr_clear, tmr_en;

  assign len_bad   = ($signed(eng_N) < 32'sd1) || ($signed(eng_N) > DATA_WIDTH);
  assign both_done = (fwd_seen || fwd_done) && (bwd_seen || bwd_done);
  assign tmr_clear = (state == CHECK) || (state == FB_RUN && both_done);
  assign tmr_en    = (state == FB_RUN) || (state == LIK_RUN);

  phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_tag   <= '0;
      bus.out_err   <= ERR_OK;
      start_fwd     <= 1'b0;
      start_bwd     <= 1'b0;
      start_lik     <= 1'b0;
      busy          <= 1'b0;
      eng_strand    <= '0;
      eng_N         <= '0;
      tag_cnt       <= '0;
      fwd_seen      <= 1'b0;
      bwd_seen      <= 1'b0;
    end else begin
      start_fwd <= 1'b0;
      start_bwd <= 1'b0;
      start_lik <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            eng_strand   <= bus.in_strand;
            eng_N        <= bus.in_N;
            bus.out_tag  <= tag_cnt;
            tag_cnt      <= tag_cnt + 1'b1;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (len_bad) begin
            bus.out_err   <= ERR_LEN;
            bus.out_valid <= 1'b1;
            state         <= RESULT;
          end else begin
            start_fwd <= 1'b1;
            start_bwd <= 1'b1;
            fwd_seen  <= 1'b0;
            bwd_seen  <= 1'b0;
            state     <= FB_RUN;
          end
        end
        FB_RUN: begin
          fwd_seen <= fwd_seen || fwd_done;
          bwd_seen <= bwd_seen || bwd_done;
          // Completion is checked before expiry so a done on the last cycle still wins.
          if (both_done) begin
            start_lik <= 1'b1;
            state     <= LIK_RUN;
          end else if (expire) begin
            bus.out_err   <= ERR_TIMEOUT;
            bus.out_valid <= 1'b1;
            state         <= RESULT;
          end
        end
        LIK_RUN: begin
          if (lik_done) begin
            bus.out_err   <= ERR_OK;
            bus.out_valid <= 1'b1;
            state         <= RESULT;
          end else if (expire) begin
            bus.out_err   <= ERR_TIMEOUT;
            bus.out_valid <= 1'b1;
            state         <= RESULT;
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_soft_decode_scheduler.sv
// Randomized bench for soft_decode_scheduler: emulated engines plus a timing/result model.
module tb_soft_decode_scheduler;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soft_decode_scheduler_if #(.DATA_WIDTH(DW), .TAG_W(TW)) bus ();

  logic [DW-1:0] eng_strand;
  logic [31:0]   eng_N;
  logic start_fwd, start_bwd, start_lik, busy;
  logic fwd_done, bwd_done, lik_done;

  soft_decode_scheduler #(.DATA_WIDTH(DW), .n(10), .TIMEOUT(TO), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .eng_strand (eng_strand),
    .eng_N      (eng_N),
    .start_fwd  (start_fwd),
    .start_bwd  (start_bwd),
    .fwd_done   (fwd_done),
    .bwd_done   (bwd_done),
    .start_lik  (start_lik),
    .lik_done   (lik_done),
    .busy       (busy)
  );

  int n_tot = 0;
  int n_bad = 0;
  int tag_exp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_starts"}, 64'({start_fwd, start_bwd, start_lik}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tag_err"}, 64'({bus.out_tag, bus.out_err}), 64'd0);
    chk({tag, "_eng"}, {eng_strand, eng_N}, 64'd0);
  endtask

  // One strand from offer to result handshake. Entered and left #1 after a rising edge.
  // Cycle t is the interval after the t-th edge; inputs set in iteration t apply in cycle t.
  task automatic run_strand(input logic [DW-1:0] s, input int N, input int df, input int db,
                            input int dl, input int rd, input bit lvl, input bit rst_lik);
    int acc = -1, sf = -1, sb = -1, sl = -1, ov = -1, hs = -1;
    int nf = 0, nb = 0, nl = 0;
    int unstable = 0, rdy_bad = 0, busy_bad = 0, eng_bad = 0;
    logic [TW-1:0] tag0 = '0;
    logic [1:0] err0 = '0;
    bit ok, aborted = 0;
    int m, err_e, ov_e, lik_e, sl_e;

    // Expected outcome, relative to the cycle in which the strand is accepted.
    ok = (N >= 1) && (N <= DW);
    m = (df > db) ? df : db;
    sl_e = -1;
    if (!ok) begin
      err_e = 1; ov_e = 2; lik_e = 0;
    end else if (m >= TO) begin
      err_e = 2; ov_e = 2 + TO; lik_e = 0;
    end else begin
      sl_e = 3 + m; lik_e = 1;
      if (dl >= TO) begin err_e = 2; ov_e = sl_e + TO; end
      else          begin err_e = 0; ov_e = sl_e + dl + 1; end
    end

    for (int t = 0; t < 200; t++) begin
      if (start_fwd) begin nf++; if (sf < 0) sf = t; end
      if (start_bwd) begin nb++; if (sb < 0) sb = t; end
      if (start_lik) begin nl++; if (sl < 0) sl = t; end
      if (bus.out_valid) begin
        if (ov < 0) begin
          ov = t; tag0 = bus.out_tag; err0 = bus.out_err;
        end else if (bus.out_tag !== tag0 || bus.out_err !== err0) unstable++;
      end
      if (busy !== (acc >= 0) || bus.in_ready !== (acc < 0)) busy_bad++;
      if (acc >= 0 && (eng_N !== N || eng_strand !== s)) eng_bad++;

      if (rst_lik && sl >= 0) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_mid");
        tag_exp = 0;
        aborted = 1;
        bus.in_valid = 1'b0;
        fwd_done = 1'b0; bwd_done = 1'b0; lik_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        break;
      end

      if (acc < 0) begin
        bus.in_valid = 1'b1; bus.in_strand = s; bus.in_N = N;
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_strand = $urandom;
        bus.in_N = $urandom_range(1, DW);
      end
      fwd_done = (sf >= 0) && (lvl ? (t >= sf + df) : (t == sf + df));
      bwd_done = (sb >= 0) && (lvl ? (t >= sb + db) : (t == sb + db));
      lik_done = (sl >= 0) && (t == sl + dl);
      bus.out_ready = (ov >= 0) ? (t >= ov + rd) : 1'($urandom_range(0, 1));

      if (ov >= 0 && bus.in_ready) rdy_bad++;
      if (acc < 0 && bus.in_valid && bus.in_ready) acc = t;
      if (bus.out_valid && bus.out_ready) hs = t;
      @(posedge clk); #1;
      if (hs >= 0) break;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    fwd_done = 1'b0; bwd_done = 1'b0; lik_done = 1'b0;

    if (!aborted) begin
      chk("handshake", 64'(hs >= 0), 64'd1);
      chk("accept", 64'(acc), 64'd0);
      chk("tag", 64'(tag0), 64'(tag_exp));
      chk("err", 64'(err0), 64'(err_e));
      chk("ov_lat", 64'(ov - acc), 64'(ov_e));
      chk("n_fwd", 64'(nf), 64'(ok));
      chk("n_bwd", 64'(nb), 64'(ok));
      if (ok) chk("fwd_bwd_at", 64'({sf - acc, sb - acc}), {32'd2, 32'd2});
      chk("n_lik", 64'(nl), 64'(lik_e));
      if (lik_e != 0) chk("lik_at", 64'(sl - acc), 64'(sl_e));
      chk("hold_stable", 64'(unstable), 64'd0);
      chk("hold_rdy", 64'(rdy_bad), 64'd0);
      chk("busy_rdy", 64'(busy_bad), 64'd0);
      chk("eng_hold", 64'(eng_bad), 64'd0);
      tag_exp = (tag_exp + 1) % (1 << TW);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_strand = '0; bus.in_N = '0; bus.out_ready = 1'b0;
    fwd_done = 1'b0; bwd_done = 1'b0; lik_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // directed: same-cycle done, staggered done, ideal latency, bad lengths
    run_strand(32'hDEAD_BEEF, 16, 1, 1, 3, 0, 0, 0);
    run_strand(32'h1234_5678, 20, 2, 9, 1, 0, 0, 0);
    run_strand(32'h0000_00FF, 8, 1, 1, 1, 0, 0, 0);
    run_strand(32'hCAFE_0001, 0, 1, 1, 1, 0, 0, 0);
    run_strand(32'hCAFE_0002, 33, 1, 1, 1, 0, 0, 0);
    run_strand(32'hCAFE_0003, -1, 1, 1, 1, 0, 0, 0);
    run_strand(32'hCAFE_0004, 32'h7FFF_FFFF, 1, 1, 1, 1, 0, 0);
    run_strand(32'h0000_0001, 1, 3, 2, 2, 0, 1, 0);
    run_strand(32'hFFFF_FFFF, 32, 1, 4, 2, 0, 1, 0);
    // timeouts and the last-cycle boundary in each phase
    run_strand(32'hA5A5_A5A5, 12, 2, NEVER, 1, 0, 0, 0);
    run_strand(32'hA5A5_0000, 12, TO - 1, 1, 1, 0, 0, 0);
    run_strand(32'hA5A5_0001, 12, TO, 1, 1, 0, 0, 0);
    run_strand(32'hA5A5_0002, 12, 1, 1, TO - 1, 0, 0, 0);
    run_strand(32'hA5A5_0003, 12, 1, 1, NEVER, 0, 0, 0);
    // consumer stall, level-style engine dones ignored during the likelihood phase
    run_strand(32'h5A5A_5A5A, 24, 2, 3, 2, 10, 1, 0);
    // reset in LIK_RUN, then the tag restarts at 0
    run_strand(32'h0BAD_F00D, 10, 1, 2, 6, 0, 0, 1);
    run_strand(32'h600D_F00D, 10, 1, 1, 1, 0, 0, 0);
    run_strand(32'h0, 0, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int N, df, db, dl;
      N  = $urandom_range(0, DW + 2);
      df = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 8);
      db = $urandom_range(1, 8);
      dl = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 6);
      run_strand($urandom, N, df, db, dl, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
    end

    // quick bad-length strands to carry the tag counter through its wrap
    for (int i = 0; i < 260; i++) run_strand($urandom, DW + 1, 1, 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
